// File: rtl/nios_mult_unit.sv
// -----------------------------------------------------------------------------
// nios_mult_unit
//
// Pipelined integer multiply unit for the Nios execute/memory path.
//
// The full 2*DATA_W product is assembled from four DATA_W/2 x DATA_W/2
// unsigned partial products. The signed high-word modes are then obtained by
// subtracting the appropriate operand from the unsigned high word. The
// original operands travel down the pipeline with the partial products so the
// correction can be applied in the summing stage.
//
// Parameters
//   DATA_W   operand width (even, 8..64)
//   LATENCY  register stages from issue to result (1..4)
//   TAG_W    width of the destination tag carried with each operation
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   in_valid    issue strobe, sampled only when en=1
//   in_op       00 MUL (low word), 01 MULXSS, 10 MULXSU, 11 MULXUU (high word)
//   in_src1     operand A (signed for MULXSS / MULXSU)
//   in_src2     operand B (signed for MULXSS only)
//   in_tag      destination tag
//   en          pipeline advance; 0 = stall, every register holds
//   flush       clears every in-flight operation at the next edge
//   out_valid   result valid
//   out_result  selected product word
//   out_tag     tag belonging to out_result
//   busy        OR of every stage valid bit
//
// Valid semantics: there is no back-pressure handshake. An operation enters
// when in_valid=1 and en=1 at a clock edge with flush=0. Each stage valid bit
// follows valid_next = prev_valid & en & ~flush, and holds when en=0 and
// flush=0. flush clears all valid bits regardless of en. out_valid is high
// for every cycle the result sits in the last stage, including while stalled.
// -----------------------------------------------------------------------------
module nios_mult_unit #(
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [1:0]        in_op,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              en,
   input  logic              flush,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);

   localparam int H  = DATA_W / 2;
   localparam int PW = 2 * DATA_W;
   // Stages holding a finished result word. With LATENCY=1 the single stage
   // does everything; otherwise stage 1 holds partial products and the rest
   // hold the result (the first one computes it, the others only delay it).
   localparam int RS = (LATENCY == 1) ? 1 : LATENCY - 1;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSS = 2'b01;
   localparam logic [1:0] OP_MULXSU = 2'b10;
   localparam logic [1:0] OP_MULXUU = 2'b11;

   typedef struct packed {
      logic [DATA_W-1:0] ll;   // src1.lo * src2.lo
      logic [DATA_W-1:0] lh;   // src1.lo * src2.hi
      logic [DATA_W-1:0] hl;   // src1.hi * src2.lo
      logic [DATA_W-1:0] hh;   // src1.hi * src2.hi
   } pp_t;

   // Four unsigned H x H products, each exactly DATA_W bits wide.
   function automatic pp_t partials(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
      pp_t p;
      p.ll = DATA_W'(a[H-1:0])      * DATA_W'(b[H-1:0]);
      p.lh = DATA_W'(a[H-1:0])      * DATA_W'(b[DATA_W-1:H]);
      p.hl = DATA_W'(a[DATA_W-1:H]) * DATA_W'(b[H-1:0]);
      p.hh = DATA_W'(a[DATA_W-1:H]) * DATA_W'(b[DATA_W-1:H]);
      return p;
   endfunction

   // Sum the partial products modulo 2^PW, apply the signed correction to the
   // high word and select the word the op asks for.
   function automatic logic [DATA_W-1:0] final_word(input pp_t               p,
                                                    input logic [1:0]        op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
      logic [PW-1:0]     sum;
      logic [DATA_W-1:0] hi;
      logic              corr_a;
      logic              corr_b;
      sum = PW'(p.ll)
          + (PW'(p.lh) << H)
          + (PW'(p.hl) << H)
          + (PW'(p.hh) << DATA_W);
      // A negative signed operand x contributes x_unsigned - 2^DATA_W, so the
      // product gains -(other operand) << DATA_W; only the high word moves.
      corr_a = ((op == OP_MULXSS) || (op == OP_MULXSU)) && a[DATA_W-1];
      corr_b = (op == OP_MULXSS) && b[DATA_W-1];
      hi = sum[PW-1:DATA_W];
      if (corr_a) hi = hi - b;
      if (corr_b) hi = hi - a;
      return (op == OP_MUL) ? sum[DATA_W-1:0] : hi;
   endfunction

   // Feed into the first result stage.
   logic              head_valid;
   logic [DATA_W-1:0] head_data;
   logic [TAG_W-1:0]  head_tag;
   logic              s1_busy;

   generate
      if (LATENCY == 1) begin : g_single
         // Partial products and final sum in one combinational stage.
         assign head_valid = in_valid;
         assign head_data  = final_word(partials(in_src1, in_src2), in_op,
                                        in_src1, in_src2);
         assign head_tag   = in_tag;
         assign s1_busy    = 1'b0;
      end else begin : g_split
         logic              s1_valid;
         logic [1:0]        s1_op;
         logic [TAG_W-1:0]  s1_tag;
         logic [DATA_W-1:0] s1_src1;
         logic [DATA_W-1:0] s1_src2;
         pp_t               s1_pp;

         // Issue stage: partial products plus everything the sum stage needs.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s1_valid <= 1'b0;
               s1_op    <= OP_MUL;
               s1_tag   <= '0;
               s1_src1  <= '0;
               s1_src2  <= '0;
               s1_pp    <= '0;
            end else begin
               if (flush)   s1_valid <= 1'b0;
               else if (en) s1_valid <= in_valid;
               // Data only moves for a real operation, keeping idle toggling low.
               if (en && in_valid) begin
                  s1_op   <= in_op;
                  s1_tag  <= in_tag;
                  s1_src1 <= in_src1;
                  s1_src2 <= in_src2;
                  s1_pp   <= partials(in_src1, in_src2);
               end
            end
         end

         assign head_valid = s1_valid;
         assign head_data  = final_word(s1_pp, s1_op, s1_src1, s1_src2);
         assign head_tag   = s1_tag;
         assign s1_busy    = s1_valid;
      end
   endgenerate

   // Result stages; index RS-1 drives the outputs.
   logic [RS-1:0]             rs_valid;
   logic [RS-1:0][DATA_W-1:0] rs_data;
   logic [RS-1:0][TAG_W-1:0]  rs_tag;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rs_valid <= '0;
         rs_data  <= '0;
         rs_tag   <= '0;
      end else begin
         if (flush) begin
            rs_valid <= '0;
         end else if (en) begin
            rs_valid[0] <= head_valid;
            for (int i = 1; i < RS; i++) rs_valid[i] <= rs_valid[i-1];
         end
         if (en) begin
            if (head_valid) begin
               rs_data[0] <= head_data;
               rs_tag[0]  <= head_tag;
            end
            for (int i = 1; i < RS; i++) begin
               if (rs_valid[i-1]) begin
                  rs_data[i] <= rs_data[i-1];
                  rs_tag[i]  <= rs_tag[i-1];
               end
            end
         end
      end
   end

   assign out_valid  = rs_valid[RS-1];
   assign out_result = rs_data[RS-1];
   assign out_tag    = rs_tag[RS-1];
   assign busy       = s1_busy | (|rs_valid);

endmodule

// File: tb/tb_nios_mult_unit.sv
// -----------------------------------------------------------------------------
// tb_nios_mult_unit
//
// Directed bench for nios_mult_unit. Four instances share clock and reset:
//   m_ : DATA_W=32, LATENCY=2 (main: modes, corners, stall, flush, reset)
//   a_ : DATA_W=16, LATENCY=4 (long pipe, flush with two ops in flight)
//   b_ : DATA_W=8,  LATENCY=3
//   c_ : DATA_W=64, LATENCY=1
// Inputs change #1 after the rising edge; outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_nios_mult_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;

   // main instance
   logic        m_in_valid, m_en, m_flush, m_out_valid, m_busy;
   logic [1:0]  m_in_op;
   logic [31:0] m_src1, m_src2, m_out_result;
   logic [4:0]  m_in_tag, m_out_tag;
   // 16-bit, latency 4
   logic        a_in_valid, a_en, a_flush, a_out_valid, a_busy;
   logic [1:0]  a_in_op;
   logic [15:0] a_src1, a_src2, a_out_result;
   logic [4:0]  a_in_tag, a_out_tag;
   // 8-bit, latency 3
   logic        b_in_valid, b_en, b_flush, b_out_valid, b_busy;
   logic [1:0]  b_in_op;
   logic [7:0]  b_src1, b_src2, b_out_result;
   logic [4:0]  b_in_tag, b_out_tag;
   // 64-bit, latency 1
   logic        c_in_valid, c_en, c_flush, c_out_valid, c_busy;
   logic [1:0]  c_in_op;
   logic [63:0] c_src1, c_src2, c_out_result;
   logic [4:0]  c_in_tag, c_out_tag;

   nios_mult_unit #(.DATA_W(32), .LATENCY(2), .TAG_W(5)) u_main (
      .clk(clk), .reset_n(reset_n), .in_valid(m_in_valid), .in_op(m_in_op),
      .in_src1(m_src1), .in_src2(m_src2), .in_tag(m_in_tag), .en(m_en),
      .flush(m_flush), .out_valid(m_out_valid), .out_result(m_out_result),
      .out_tag(m_out_tag), .busy(m_busy));

   nios_mult_unit #(.DATA_W(16), .LATENCY(4), .TAG_W(5)) u_w16 (
      .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_op(a_in_op),
      .in_src1(a_src1), .in_src2(a_src2), .in_tag(a_in_tag), .en(a_en),
      .flush(a_flush), .out_valid(a_out_valid), .out_result(a_out_result),
      .out_tag(a_out_tag), .busy(a_busy));

   nios_mult_unit #(.DATA_W(8), .LATENCY(3), .TAG_W(5)) u_w8 (
      .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_op(b_in_op),
      .in_src1(b_src1), .in_src2(b_src2), .in_tag(b_in_tag), .en(b_en),
      .flush(b_flush), .out_valid(b_out_valid), .out_result(b_out_result),
      .out_tag(b_out_tag), .busy(b_busy));

   nios_mult_unit #(.DATA_W(64), .LATENCY(1), .TAG_W(5)) u_w64 (
      .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_op(c_in_op),
      .in_src1(c_src1), .in_src2(c_src2), .in_tag(c_in_tag), .en(c_en),
      .flush(c_flush), .out_valid(c_out_valid), .out_result(c_out_result),
      .out_tag(c_out_tag), .busy(c_busy));

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   logic [31:0] r_a, r_b, r_exp;
   logic [1:0]  r_op;

   task automatic chk(input string name, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // 32-bit reference: sign/zero-extend to 64 bits and multiply.
   function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      m_in_valid = 0; m_in_op = 0; m_src1 = 0; m_src2 = 0; m_in_tag = 0; m_en = 1; m_flush = 0;
      a_in_valid = 0; a_in_op = 0; a_src1 = 0; a_src2 = 0; a_in_tag = 0; a_en = 1; a_flush = 0;
      b_in_valid = 0; b_in_op = 0; b_src1 = 0; b_src2 = 0; b_in_tag = 0; b_en = 1; b_flush = 0;
      c_in_valid = 0; c_in_op = 0; c_src1 = 0; c_src2 = 0; c_in_tag = 0; c_en = 1; c_flush = 0;
      #2 reset_n = 1'b0;
      step(); step(); step();
      chk("rst_valid", m_out_valid, 0);
      chk("rst_result", m_out_result, 0);
      chk("rst_tag", m_out_tag, 0);
      chk("rst_busy", m_busy, 0);
      reset_n = 1'b1;
      step();
      chk("idle_valid", m_out_valid, 0);

      // ---- all four modes on all-ones operands, back to back
      m_in_valid = 1; m_src1 = 32'hFFFF_FFFF; m_src2 = 32'hFFFF_FFFF;
      m_in_op = 2'b00; m_in_tag = 1; step();
      chk("mode_lat", m_out_valid, 0);
      m_in_op = 2'b01; m_in_tag = 2; step();
      chk("mul_valid", m_out_valid, 1);
      chk("mul_res", m_out_result, 32'h0000_0001);
      chk("mul_tag", m_out_tag, 1);
      m_in_op = 2'b10; m_in_tag = 3; step();
      chk("mulxss_res", m_out_result, 32'h0000_0000);
      chk("mulxss_tag", m_out_tag, 2);
      m_in_op = 2'b11; m_in_tag = 4; step();
      chk("mulxsu_res", m_out_result, 32'hFFFF_FFFF);
      chk("mulxsu_tag", m_out_tag, 3);
      m_in_valid = 0; step();
      chk("mulxuu_valid", m_out_valid, 1);
      chk("mulxuu_res", m_out_result, 32'hFFFF_FFFE);
      chk("mulxuu_tag", m_out_tag, 4);
      step();
      chk("drain_valid", m_out_valid, 0);
      chk("drain_busy", m_busy, 0);

      // ---- signed corners
      m_in_valid = 1; m_in_op = 2'b01; m_src1 = 32'h8000_0000; m_src2 = 32'h8000_0000;
      m_in_tag = 5; step();
      m_src2 = 32'h0000_0002; m_in_tag = 6; step();
      chk("ss_minmin", m_out_result, 32'h4000_0000);
      chk("ss_minmin_tag", m_out_tag, 5);
      m_in_op = 2'b00; m_in_tag = 7; step();
      chk("ss_minx2", m_out_result, 32'hFFFF_FFFF);
      m_in_valid = 0; step();
      chk("mul_minx2", m_out_result, 32'h0000_0000);
      chk("mul_minx2_tag", m_out_tag, 7);
      step();

      // ---- stall: 7*6 frozen in stage 1 for five cycles
      m_in_valid = 1; m_in_op = 2'b00; m_src1 = 7; m_src2 = 6; m_in_tag = 9; step();
      m_en = 0; m_in_src_stall();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", m_out_valid, 0);
         chk("stall_busy", m_busy, 1);
      end
      m_en = 1; m_in_valid = 0; step();
      chk("stall_out_valid", m_out_valid, 1);
      chk("stall_out_res", m_out_result, 32'h0000_002A);
      chk("stall_out_tag", m_out_tag, 9);
      m_en = 0; step();
      chk("hold_valid", m_out_valid, 1);
      chk("hold_res", m_out_result, 32'h0000_002A);
      m_en = 1; step();
      chk("after_stall_valid", m_out_valid, 0);
      chk("after_stall_busy", m_busy, 0);

      // ---- flush while stalled drops both the in-flight op and the new issue
      m_in_valid = 1; m_in_op = 2'b00; m_src1 = 3; m_src2 = 3; m_in_tag = 10; step();
      m_in_tag = 11; m_flush = 1; m_en = 0; step();
      chk("flush_valid", m_out_valid, 0);
      chk("flush_busy", m_busy, 0);
      m_flush = 0; m_en = 1; m_in_valid = 0; step();
      chk("flush_drop1", m_out_valid, 0);
      step();
      chk("flush_drop2", m_out_valid, 0);

      // ---- random vectors against the 64-bit reference
      for (int i = 0; i < 12; i++) begin
         r_a = $urandom; r_b = $urandom; r_op = 2'($urandom_range(0, 3));
         exp_q.push_back(ref_mul(r_op, r_a, r_b));
         m_in_valid = 1; m_in_op = r_op; m_src1 = r_a; m_src2 = r_b; m_in_tag = 5'(i);
         step();
         if (i > 0) begin
            r_exp = exp_q.pop_front();
            chk("rand_valid", m_out_valid, 1);
            chk("rand_res", m_out_result, r_exp);
         end
      end
      m_in_valid = 0; step();
      r_exp = exp_q.pop_front();
      chk("rand_last", m_out_result, r_exp);

      // ---- asynchronous reset with results in flight
      m_in_valid = 1; m_in_op = 2'b00; m_src1 = 2; m_src2 = 3; m_in_tag = 12; step();
      m_src1 = 4; m_src2 = 5; m_in_tag = 13; step();
      chk("pre_rst_res", m_out_result, 6);
      #2 reset_n = 1'b0;
      #1;
      chk("async_valid", m_out_valid, 0);
      chk("async_result", m_out_result, 0);
      chk("async_tag", m_out_tag, 0);
      chk("async_busy", m_busy, 0);
      m_in_valid = 0; m_src1 = 0; m_src2 = 0; m_in_tag = 0;
      step(); step(); step();
      reset_n = 1'b1;
      step();
      chk("post_rst_valid", m_out_valid, 0);
      chk("post_rst_busy", m_busy, 0);
      chk("post_rst_result", m_out_result, 0);

      // ---- 16-bit, latency 4
      a_in_valid = 1; a_in_op = 2'b11; a_src1 = 16'hFFFF; a_src2 = 16'hFFFF; a_in_tag = 1;
      step();
      a_in_valid = 0;
      step(); chk("w16_lat2", a_out_valid, 0);
      step(); chk("w16_lat3", a_out_valid, 0);
      step();
      chk("w16_uu_valid", a_out_valid, 1);
      chk("w16_uu_res", a_out_result, 16'hFFFE);
      chk("w16_uu_tag", a_out_tag, 1);
      a_in_valid = 1; a_in_op = 2'b01; a_src1 = 16'h8000; a_src2 = 16'h8000; a_in_tag = 2; step();
      a_in_op = 2'b10; a_src1 = 16'hFFFF; a_src2 = 16'h0002; a_in_tag = 3; step();
      a_src1 = 16'h0002; a_src2 = 16'hFFFF; a_in_tag = 4; step();
      a_in_valid = 0; step();
      chk("w16_ss_res", a_out_result, 16'h4000);
      step();
      chk("w16_su_neg", a_out_result, 16'hFFFF);
      step();
      chk("w16_su_pos", a_out_result, 16'h0001);
      chk("w16_su_pos_tag", a_out_tag, 4);
      step();
      chk("w16_idle", a_busy, 0);
      // two ops in flight, third issued in the flush cycle
      a_in_valid = 1; a_in_op = 2'b00; a_src1 = 5; a_src2 = 5; a_in_tag = 5; step();
      a_in_tag = 6; step();
      a_in_tag = 7; a_flush = 1; step();
      chk("w16_flush_busy", a_busy, 0);
      chk("w16_flush_valid", a_out_valid, 0);
      a_flush = 0; a_in_valid = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("w16_flush_drop", a_out_valid, 0);
      end

      // ---- 8-bit, latency 3
      b_in_valid = 1; b_in_op = 2'b01; b_src1 = 8'h80; b_src2 = 8'h80; b_in_tag = 1; step();
      b_in_op = 2'b00; b_src1 = 8'h10; b_src2 = 8'h10; b_in_tag = 2; step();
      b_in_op = 2'b11; b_src1 = 8'hFF; b_src2 = 8'hFF; b_in_tag = 3; step();
      chk("w8_ss_res", b_out_result, 8'h40);
      chk("w8_ss_valid", b_out_valid, 1);
      b_in_valid = 0; step();
      chk("w8_mul_res", b_out_result, 8'h00);
      chk("w8_mul_tag", b_out_tag, 2);
      step();
      chk("w8_uu_res", b_out_result, 8'hFE);
      step();
      chk("w8_idle", b_out_valid, 0);

      // ---- 64-bit, latency 1
      c_in_valid = 1; c_in_op = 2'b00; c_src1 = 3; c_src2 = 5; c_in_tag = 1; step();
      chk("w64_mul_valid", c_out_valid, 1);
      chk("w64_mul_res", c_out_result, 64'd15);
      c_in_op = 2'b11; c_src1 = 64'hFFFF_FFFF_FFFF_FFFF; c_src2 = 64'hFFFF_FFFF_FFFF_FFFF;
      c_in_tag = 2; step();
      chk("w64_uu_res", c_out_result, 64'hFFFF_FFFF_FFFF_FFFE);
      c_in_op = 2'b01; c_src2 = 64'd2; c_in_tag = 3; step();
      chk("w64_ss_res", c_out_result, 64'hFFFF_FFFF_FFFF_FFFF);
      c_in_op = 2'b10; c_src1 = 64'd2; c_src2 = 64'hFFFF_FFFF_FFFF_FFFF; c_in_tag = 4; step();
      chk("w64_su_res", c_out_result, 64'd1);
      chk("w64_su_tag", c_out_tag, 4);
      c_in_valid = 0; step();
      chk("w64_idle", c_out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // During the stall an issue request is presented; it must be ignored.
   task automatic m_in_src_stall();
      m_in_valid = 1; m_in_op = 2'b00; m_src1 = 9; m_src2 = 9; m_in_tag = 15;
   endtask

endmodule
